load_return_unit: RTL and testbench

//  Load-side counterpart of the X-stage store path: X stage issues a load (funct3, addr offset, rd),

---
 rtl/load_return_unit_pkg.sv | 29 ++
 rtl/load_return_unit_if.sv | 30 +++
 rtl/load_extract.sv | 29 ++
 rtl/load_return_unit.sv | 113 +++++++++++
 tb/tb_load_return_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/load_return_unit_pkg.sv
// Shared load/store constants (funct3 encodings, opcode) plus the load-return FSM states
// and the captured-request payload.
package load_return_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned OFF_W    = 2;

  localparam logic [F3_W-1:0] FNC_LB   = 3'b000;
  localparam logic [F3_W-1:0] FNC_LH   = 3'b001;
  localparam logic [F3_W-1:0] FNC_LW   = 3'b010;
  localparam logic [F3_W-1:0] FNC_LBU  = 3'b100;
  localparam logic [F3_W-1:0] FNC_LHU  = 3'b101;
  localparam logic [6:0]      OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } lru_state_e;

  typedef struct packed {
    logic [F3_W-1:0]  funct3;
    logic [OFF_W-1:0] offset;
    logic [RD_W-1:0]  rd;
  } lru_req_t;

endpackage

// File: rtl/load_return_unit_if.sv
// Load issue / memory response / writeback bundle between X stage, dmem and the load-return unit.
interface load_return_unit_if;
  import load_return_unit_pkg::*;

  logic              req_valid;
  logic [F3_W-1:0]   req_funct3;
  logic [OFF_W-1:0]  req_addr_offset;
  logic [RD_W-1:0]   req_rd;
  logic              kill;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_data;
  logic              stall;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              timeout_err;

  modport master (
    output req_valid, req_funct3, req_addr_offset, req_rd, kill,
    output dmem_resp_valid, dmem_resp_data,
    input  stall, wb_valid, wb_rd, wb_data, timeout_err
  );

  modport slave (
    input  req_valid, req_funct3, req_addr_offset, req_rd, kill,
    input  dmem_resp_valid, dmem_resp_data,
    output stall, wb_valid, wb_rd, wb_data, timeout_err
  );

endinterface

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word of an aligned memory word and sign/zero-extends it.
module load_extract
  import load_return_unit_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ext_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half select ignores offset[0], matching the store side.
  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? data[31:16] : data[15:0];
    ext_data_c = '0;
    case (funct3)
      FNC_LB:  ext_data_c = {{24{byte_sel[7]}}, byte_sel};
      FNC_LH:  ext_data_c = {{16{half_sel[15]}}, half_sel};
      FNC_LW:  ext_data_c = data;
      FNC_LBU: ext_data_c = {24'd0, byte_sel};
      FNC_LHU: ext_data_c = {16'd0, half_sel};
      default: ext_data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_return_unit.sv
// Tracks one outstanding load: waits for dmem, extracts the result, registers the writeback,
// stalls the pipe meanwhile, and handles kill and response timeout.
module load_return_unit
  import load_return_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic               clk,
  input logic               reset_n,
  load_return_unit_if.slave bus
);

  lru_state_e        state_q, state_d;
  lru_req_t          cap_q, cap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_q, stall_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              timeout_q, timeout_d;
  logic              timeout_hit;
  logic [DATA_W-1:0] ext_data;

  load_extract u_extract (
    .funct3     (cap_q.funct3),
    .offset     (cap_q.offset),
    .data       (bus.dmem_resp_data),
    .ext_data_c (ext_data)
  );

  // Timeout check only matters when no response arrives; a response in the hit cycle completes.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      cnt_q      <= '0;
      stall_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          cap_d.funct3 = bus.req_funct3;
          cap_d.offset = bus.req_addr_offset;
          cap_d.rd     = bus.req_rd;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.dmem_resp_valid && !bus.kill) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = cap_q.rd;
          wb_data_d  = ext_data;
          state_d    = ST_IDLE;
        end else if (bus.dmem_resp_valid) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.kill) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.dmem_resp_valid) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_d = (state_d != ST_IDLE);
  end

  assign bus.stall       = stall_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_load_return_unit.sv
// Directed bench for load_return_unit: one instance with the default timeout, one with a short timeout.
module tb_load_return_unit;
  import load_return_unit_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  load_return_unit_if bus();
  load_return_unit_if bus_to();

  load_return_unit #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  load_return_unit #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut_to (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = 1'b0;  bus.req_funct3 = '0;  bus.req_addr_offset = '0;  bus.req_rd = '0;
    bus.kill = 1'b0;  bus.dmem_resp_valid = 1'b0;  bus.dmem_resp_data = '0;
    bus_to.req_valid = 1'b0;  bus_to.req_funct3 = '0;  bus_to.req_addr_offset = '0;
    bus_to.req_rd = '0;  bus_to.kill = 1'b0;  bus_to.dmem_resp_valid = 1'b0;
    bus_to.dmem_resp_data = '0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    bus.req_valid = 1'b1;  bus.req_funct3 = f3;  bus.req_addr_offset = off;  bus.req_rd = rd;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic load_and_check(input string tag, input logic [2:0] f3, input logic [1:0] off,
                                input logic [4:0] rd, input logic [31:0] d, input logic [31:0] exp);
    issue(f3, off, rd);
    bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = d;
    step();
    bus.dmem_resp_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.wb_valid), 32'd1);
    check({tag, "_rd"},    32'(bus.wb_rd), 32'(rd));
    check({tag, "_data"},  bus.wb_data, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);

    // 1: LB off=2 with 1-cycle response
    issue(FNC_LB, 2'd2, 5'd5);
    check("lb_stall", 32'(bus.stall), 32'd1);
    check("lb_wb_early", 32'(bus.wb_valid), 32'd0);
    bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'h1280_3456;
    step();
    bus.dmem_resp_valid = 1'b0;
    check("lb_valid", 32'(bus.wb_valid), 32'd1);
    check("lb_rd", 32'(bus.wb_rd), 32'd5);
    check("lb_data", bus.wb_data, 32'hFFFF_FF80);
    check("lb_stall_done", 32'(bus.stall), 32'd0);
    step();
    check("lb_pulse_valid", 32'(bus.wb_valid), 32'd0);
    check("lb_pulse_rd", 32'(bus.wb_rd), 32'd0);
    check("lb_pulse_data", bus.wb_data, 32'd0);

    // 2: extraction patterns
    load_and_check("lhu_off2", FNC_LHU, 2'd2, 5'd6,  32'h8001_7FFF, 32'h0000_8001);
    load_and_check("lh_off0",  FNC_LH,  2'd0, 5'd7,  32'h8001_7FFF, 32'h0000_7FFF);
    load_and_check("lh_off2",  FNC_LH,  2'd2, 5'd8,  32'h8001_7FFF, 32'hFFFF_8001);
    load_and_check("lh_off3",  FNC_LH,  2'd3, 5'd8,  32'h8001_7FFF, 32'hFFFF_8001);
    load_and_check("lw_off3",  FNC_LW,  2'd3, 5'd10, 32'h8001_7FFF, 32'h8001_7FFF);
    load_and_check("lbu_off1", FNC_LBU, 2'd1, 5'd11, 32'h1280_3456, 32'h0000_0034);
    load_and_check("lbu_off2", FNC_LBU, 2'd2, 5'd12, 32'h1280_3456, 32'h0000_0080);
    load_and_check("lb_off0",  FNC_LB,  2'd0, 5'd13, 32'h1280_3456, 32'h0000_0056);
    load_and_check("bad_f3",   3'b011,  2'd0, 5'd14, 32'hDEAD_BEEF, 32'h0000_0000);
    load_and_check("rd_zero",  FNC_LW,  2'd0, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D);

    // 3: response arrives in the fifth stall cycle, then back-to-back issue
    issue(FNC_LW, 2'd0, 5'd9);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("dly_stall_%0d", c), 32'(bus.stall), 32'd1);
      check($sformatf("dly_nowb_%0d", c), 32'(bus.wb_valid), 32'd0);
      if (c == 5) begin
        bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'h0BAD_CAFE;
      end
      step();
    end
    bus.dmem_resp_valid = 1'b0;
    check("dly_valid", 32'(bus.wb_valid), 32'd1);
    check("dly_data", bus.wb_data, 32'h0BAD_CAFE);
    check("dly_stall_low", 32'(bus.stall), 32'd0);
    load_and_check("b2b", FNC_LBU, 2'd0, 5'd3, 32'h0000_00F1, 32'h0000_00F1);

    // 4a: kill in second WAIT cycle, response two cycles later
    issue(FNC_LW, 2'd0, 5'd4);
    step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("drain_stall_3", 32'(bus.stall), 32'd1);
    step();
    check("drain_stall_4", 32'(bus.stall), 32'd1);
    bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'h1111_2222;
    step();
    bus.dmem_resp_valid = 1'b0;
    check("drain_stall_low", 32'(bus.stall), 32'd0);
    check("drain_no_wb", 32'(bus.wb_valid), 32'd0);
    step();
    check("drain_no_wb_after", 32'(bus.wb_valid), 32'd0);

    // 4b: kill with same-cycle response
    issue(FNC_LW, 2'd0, 5'd4);
    bus.kill = 1'b1;  bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'h3333_4444;
    step();
    bus.kill = 1'b0;  bus.dmem_resp_valid = 1'b0;
    check("killresp_stall", 32'(bus.stall), 32'd0);
    check("killresp_no_wb", 32'(bus.wb_valid), 32'd0);

    // 4c: req+kill in IDLE, then stale response in IDLE
    bus.kill = 1'b1;
    issue(FNC_LW, 2'd0, 5'd15);
    bus.kill = 1'b0;
    check("idle_kill_stall", 32'(bus.stall), 32'd0);
    bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'h5555_6666;
    step();
    bus.dmem_resp_valid = 1'b0;
    check("stale_no_wb", 32'(bus.wb_valid), 32'd0);
    check("stale_stall", 32'(bus.stall), 32'd0);

    // 5a: timeout of 4 with no response
    bus_to.req_valid = 1'b1;  bus_to.req_funct3 = FNC_LW;  bus_to.req_rd = 5'd2;
    step();
    bus_to.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("to_stall_%0d", c), 32'(bus_to.stall), 32'd1);
      check($sformatf("to_noerr_%0d", c), 32'(bus_to.timeout_err), 32'd0);
      step();
    end
    check("to_err", 32'(bus_to.timeout_err), 32'd1);
    check("to_stall_low", 32'(bus_to.stall), 32'd0);
    check("to_no_wb", 32'(bus_to.wb_valid), 32'd0);
    bus_to.dmem_resp_valid = 1'b1;  bus_to.dmem_resp_data = 32'h7777_8888;
    step();
    bus_to.dmem_resp_valid = 1'b0;
    check("to_err_pulse", 32'(bus_to.timeout_err), 32'd0);
    check("to_late_no_wb", 32'(bus_to.wb_valid), 32'd0);
    check("to_late_stall", 32'(bus_to.stall), 32'd0);

    // 5b: response in the same cycle the counter hits wins
    bus_to.req_valid = 1'b1;  bus_to.req_funct3 = FNC_LW;  bus_to.req_rd = 5'd17;
    step();
    bus_to.req_valid = 1'b0;
    repeat (4) step();
    bus_to.dmem_resp_valid = 1'b1;  bus_to.dmem_resp_data = 32'h9999_AAAA;
    step();
    bus_to.dmem_resp_valid = 1'b0;
    check("hit_wb_valid", 32'(bus_to.wb_valid), 32'd1);
    check("hit_wb_data", bus_to.wb_data, 32'h9999_AAAA);
    check("hit_no_err", 32'(bus_to.timeout_err), 32'd0);

    // 6: async reset mid-cycle while waiting
    issue(FNC_LW, 2'd0, 5'd21);
    check("arst_pre_stall", 32'(bus.stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_wb_valid", 32'(bus.wb_valid), 32'd0);
    step();
    reset_n = 1'b1;
    bus.dmem_resp_valid = 1'b1;  bus.dmem_resp_data = 32'hBBBB_CCCC;
    step();
    bus.dmem_resp_valid = 1'b0;
    check("arst_resp_no_wb", 32'(bus.wb_valid), 32'd0);
    check("arst_resp_data", bus.wb_data, 32'd0);
    check("arst_resp_stall", 32'(bus.stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
